// File: rtl/tone_decoder_pkg.sv
// Shared note table for the piano tone generator and the tone decoder.
// Note indices follow the piano switch/LED bus order (7 = C4 .. 0 = C5).
package tone_decoder_pkg;

   localparam int NUM_NOTES = 8;

   localparam int NOTE_C5 = 0;
   localparam int NOTE_B4 = 1;
   localparam int NOTE_A4 = 2;
   localparam int NOTE_G4 = 3;
   localparam int NOTE_F4 = 4;
   localparam int NOTE_E4 = 5;
   localparam int NOTE_D4 = 6;
   localparam int NOTE_C4 = 7;

   // Note frequencies in centi-Hz, element [i] belongs to note index i.
   localparam logic [NUM_NOTES-1:0][31:0] NOTE_FREQ_CHZ = {
      32'd26163, 32'd29366, 32'd32963, 32'd34923,
      32'd39200, 32'd44000, 32'd49388, 32'd52325
   };

   typedef logic [NUM_NOTES-1:0][31:0] period_tbl_t;

   // Classifier result: a note index 0..7, or NONE.
   typedef logic [3:0] cand_t;
   localparam cand_t CAND_NONE = 4'd8;

   typedef enum logic [1:0] {
      SILENT  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   // Rounded period in CLK cycles of note idx.
   function automatic logic [31:0] note_period(input int unsigned clk_hz, input logic [2:0] idx);
      logic [63:0] f;
      logic [63:0] num;
      f   = 64'(NOTE_FREQ_CHZ[idx]);
      num = 64'(clk_hz) * 64'd100 + (f >> 1);
      return 32'(num / f);
   endfunction

   function automatic period_tbl_t period_table(input int unsigned clk_hz);
      period_tbl_t tbl;
      for (int i = 0; i < NUM_NOTES; i++) tbl[i] = note_period(clk_hz, 3'(i));
      return tbl;
   endfunction

   function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic logic [7:0] note_onehot(input cand_t c);
      return c[3] ? 8'h00 : (8'b1 << c[2:0]);
   endfunction

endpackage

// File: rtl/tone_decoder_sync_edge_det.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// Latency from pin edge to the rise pulse is three clocks.
module tone_decoder_sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic [1:0] sync;
   logic       last;

   // NOTE: non-blocking assignments make every flop sample the pre-edge value, forming a true shift chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= 2'b00;
         last <= 1'b0;
         rise <= 1'b0;
      end else begin
         sync <= {sync[0], d};
         last <= sync[1];
         rise <= sync[1] & ~last;
      end
   end

endmodule

// File: rtl/tone_decoder.sv
// Measures the period of a square-wave tone and reports the matching C4..C5
// note one-hot, with confirmation filtering and a silence timeout.
module tone_decoder
   import tone_decoder_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int TOL_SHIFT = 6,
   parameter int CONFIRM   = 2,
   parameter int CNT_W     = 20
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       FREQ,
   output logic [7:0] note,
   output logic       valid,
   output logic       note_change
);

   localparam period_tbl_t PERIOD = period_table(CLK_HZ);
   localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(2 * PERIOD[NOTE_C4]);
   localparam int CONF_W = $clog2(CONFIRM + 1);
   localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONFIRM);

   logic              rise;
   logic [CNT_W-1:0]  count;
   logic              saturated;
   logic [31:0]       meas;
   cand_t             cand;
   cand_t             pend;
   cand_t             lock_idx;
   logic [CONF_W-1:0] conf;
   logic [CONF_W-1:0] conf_next;
   logic              confirmed;
   state_t            state;

   tone_decoder_sync_edge_det u_sync (
      .clk  (CLK),
      .rst  (RESET),
      .d    (FREQ),
      .rise (rise)
   );

   // The count seen in the rise cycle is the period; it then reloads to 1.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)                 count <= '0;
      else if (rise)             count <= CNT_W'(1);
      else if (count != TIMEOUT) count <= count + 1'b1;
   end

   assign saturated = (count == TIMEOUT);
   assign meas      = 32'(count);

   // NOTE: give every always_comb output a default before any branch so no latch is inferred.
   always_comb begin
      cand = CAND_NONE;
      for (int i = 0; i < NUM_NOTES; i++) begin
         if (abs_diff(meas, PERIOD[i[2:0]]) <= (PERIOD[i[2:0]] >> TOL_SHIFT)) cand = cand_t'(i);
      end
   end

   always_comb begin
      if (cand == pend && conf != '0) conf_next = (conf == CONF_MAX) ? conf : conf + 1'b1;
      else                            conf_next = CONF_W'(1);
   end

   assign confirmed = (conf_next == CONF_MAX);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= SILENT;
         note        <= '0;
         valid       <= 1'b0;
         note_change <= 1'b0;
         pend        <= CAND_NONE;
         lock_idx    <= CAND_NONE;
         conf        <= '0;
      end else begin
         note_change <= 1'b0;
         if (rise) begin
            unique case (state)
               SILENT: begin
                  // First edge has no predecessor, so its count is not a period.
                  state <= ACQUIRE;
                  pend  <= CAND_NONE;
                  conf  <= '0;
               end
               ACQUIRE: begin
                  pend <= cand;
                  conf <= conf_next;
                  if (confirmed && cand != CAND_NONE) begin
                     state       <= LOCKED;
                     lock_idx    <= cand;
                     note        <= note_onehot(cand);
                     valid       <= 1'b1;
                     note_change <= 1'b1;
                     pend        <= CAND_NONE;
                     conf        <= '0;
                  end
               end
               LOCKED: begin
                  if (cand == lock_idx) begin
                     pend <= CAND_NONE;
                     conf <= '0;
                  end else if (confirmed) begin
                     note_change <= 1'b1;
                     lock_idx    <= cand;
                     note        <= note_onehot(cand);
                     pend        <= CAND_NONE;
                     conf        <= '0;
                     if (cand == CAND_NONE) begin
                        valid <= 1'b0;
                        state <= ACQUIRE;
                     end
                  end else begin
                     pend <= cand;
                     conf <= conf_next;
                  end
               end
               default: state <= SILENT;
            endcase
         end else if (saturated && state != SILENT) begin
            state    <= SILENT;
            pend     <= CAND_NONE;
            lock_idx <= CAND_NONE;
            conf     <= '0;
            if (valid) begin
               note        <= '0;
               valid       <= 1'b0;
               note_change <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tone_decoder.sv
// Self-checking bench for tone_decoder: directed scenarios plus randomized
// tone sequences checked against a period-level reference model.
module tb_tone_decoder;

   localparam int CLK_HZ    = 250_000;
   localparam int TOL_SHIFT = 6;
   localparam int CONFIRM   = 2;
   localparam int CNT_W     = 20;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       FREQ = 1'b0;
   logic [7:0] note;
   logic       valid;
   logic       note_change;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;

   int per [8];
   int tol [8];
   int timeout;

   // Reference model state, updated once per FREQ rising edge.
   bit m_seen_edge = 0;
   bit m_valid     = 0;
   int m_note      = -1;
   int run_c       = -1;
   int run_n       = 0;
   int exp_pulses  = 0;
   int prev_t      = 0;

   tone_decoder #(
      .CLK_HZ    (CLK_HZ),
      .TOL_SHIFT (TOL_SHIFT),
      .CONFIRM   (CONFIRM),
      .CNT_W     (CNT_W)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .FREQ        (FREQ),
      .note        (note),
      .valid       (valid),
      .note_change (note_change)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (note_change === 1'b1) pulses++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic real note_hz(input int i);
      case (i)
         0: return 523.25;
         1: return 493.88;
         2: return 440.00;
         3: return 392.00;
         4: return 349.23;
         5: return 329.63;
         6: return 293.66;
         default: return 261.63;
      endcase
   endfunction

   function automatic int classify(input int p);
      int c = -1;
      for (int i = 0; i < 8; i++) begin
         int d = (p > per[i]) ? p - per[i] : per[i] - p;
         if (d <= tol[i]) c = i;
      end
      return c;
   endfunction

   function automatic logic [7:0] exp_note();
      return m_valid ? 8'(1 << m_note) : 8'h00;
   endfunction

   task automatic model_rise(input int gap);
      int c;
      if (!m_seen_edge) begin
         m_seen_edge = 1;
         run_n = 0;
         return;
      end
      c = classify(gap);
      if (m_valid && c == m_note) begin
         run_n = 0;
         return;
      end
      if (run_n > 0 && c == run_c) run_n++;
      else begin
         run_c = c;
         run_n = 1;
      end
      if (run_n >= CONFIRM) begin
         if (c >= 0) begin
            m_note = c;
            m_valid = 1;
            exp_pulses++;
            run_n = 0;
         end else if (m_valid) begin
            m_note = -1;
            m_valid = 0;
            exp_pulses++;
            run_n = 0;
         end
      end
   endtask

   task automatic model_timeout();
      m_seen_edge = 0;
      run_n = 0;
      if (m_valid) begin
         m_valid = 0;
         m_note = -1;
         exp_pulses++;
      end
   endtask

   // One rising edge followed by t cycles of tone (high for t/2). Entered and
   // left 2 time units after a rising CLK edge.
   task automatic tone(input int t);
      logic [7:0] old_note;
      logic       old_valid;
      int         old_pulses;
      FREQ = 1'b1;
      old_note   = exp_note();
      old_valid  = m_valid;
      old_pulses = exp_pulses;
      model_rise(prev_t);
      for (int j = 1; j <= t; j++) begin
         @(posedge CLK);
         #2;
         if (j == t / 2) FREQ = 1'b0;
         if (j == 3) begin
            check("note_before", note, old_note);
            check("valid_before", valid, old_valid);
         end
         if (j == 4) begin
            check("note_after", note, exp_note());
            check("valid_after", valid, m_valid);
            check("change_pulse", note_change, exp_pulses != old_pulses);
         end
         if (j == 5) check("change_width", note_change, 1'b0);
         if (t > timeout + 4 && j == timeout + 3) begin
            check("to_hold_note", note, exp_note());
            check("to_hold_valid", valid, m_valid);
            old_pulses = exp_pulses;
            model_timeout();
         end
         if (t > timeout + 4 && j == timeout + 4) begin
            check("to_note", note, exp_note());
            check("to_valid", valid, m_valid);
            check("to_pulse", note_change, exp_pulses != old_pulses);
         end
      end
      prev_t = t;
      check("pulse_total", pulses, exp_pulses);
   endtask

   initial begin
      int seq [9] = '{5, 5, 4, 3, 3, 4, 5, 6, 7};
      int n;
      int len;
      int kind;
      logic [7:0] sw;

      for (int i = 0; i < 8; i++) begin
         per[i] = $rtoi(real'(CLK_HZ) / note_hz(i) + 0.5);
         tol[i] = per[i] >> TOL_SHIFT;
      end
      timeout = 2 * per[7];

      // Reset held while FREQ toggles.
      RESET = 1'b1;
      for (int i = 0; i < 6; i++) begin
         repeat (20) @(posedge CLK);
         #2 FREQ = ~FREQ;
         check("rst_note", note, 8'h00);
         check("rst_valid", valid, 1'b0);
      end
      check("rst_change", note_change, 1'b0);
      FREQ = 1'b0;
      @(posedge CLK);
      #2 RESET = 1'b0;
      repeat (2 * timeout) @(posedge CLK);
      #2;
      check("idle_note", note, 8'h00);
      check("idle_valid", valid, 1'b0);
      check("idle_pulses", pulses, 0);

      // A4 lock, then steady.
      repeat (6) tone(per[2]);
      check("a4_note", note, 8'b0000_0100);
      check("a4_pulses", pulses, 1);

      // C5 near the edge of its window, then just outside any window.
      repeat (3) tone(per[0] + tol[0] - 2);
      check("c5_note", note, 8'b0000_0001);
      check("c5_pulses", pulses, 2);
      repeat (3) tone(per[0] + tol[0] + 4);
      check("none_note", note, 8'h00);
      check("none_valid", valid, 1'b0);
      check("none_pulses", pulses, 3);

      // E4 lock with a single G4 period inserted.
      repeat (3) tone(per[5]);
      tone(per[3]);
      repeat (2) tone(per[5]);
      check("glitch_note", note, 8'b0010_0000);
      check("glitch_pulses", pulses, 4);

      // C4 lock, silence timeout, relock needing three edges.
      repeat (3) tone(per[7]);
      tone(timeout + 100);
      check("silence_note", note, 8'h00);
      check("silence_pulses", pulses, 6);
      repeat (2) tone(per[7]);
      check("relock_early", valid, 1'b0);
      tone(per[7]);
      check("relock_note", note, 8'b1000_0000);

      // Reset asserted mid-measurement clears immediately.
      #1 RESET = 1'b1;
      #1;
      check("midrst_note", note, 8'h00);
      check("midrst_valid", valid, 1'b0);
      m_seen_edge = 0;
      m_valid = 0;
      m_note = -1;
      run_n = 0;
      repeat (3) @(posedge CLK);
      #2 RESET = 1'b0;
      @(posedge CLK);
      #2;
      repeat (3) tone(per[4]);
      check("after_rst_note", note, 8'b0001_0000);

      // Loopback-style stepping through the switch positions.
      foreach (seq[s]) begin
         sw = 8'(1 << seq[s]);
         repeat (3) tone(per[seq[s]]);
         check("loop_note", note, sw);
      end

      // Randomized runs: jittered notes, arbitrary periods and silences.
      for (int r = 0; r < 12; r++) begin
         kind = int'($urandom_range(0, 19));
         if (kind == 0) tone(timeout + int'($urandom_range(10, 200)));
         else if (kind < 4) tone(int'($urandom_range(420, 1000)));
         else begin
            n   = int'($urandom_range(0, 7));
            len = int'($urandom_range(1, 4));
            for (int k = 0; k < len; k++) tone(per[n] + int'($urandom_range(0, 2 * tol[n])) - tol[n]);
         end
      end
      tone(timeout + 50);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
